// File: rtl/picorv32_pkg.sv
// Shared definitions for the PicoRV32 register-file port: widths and FSM state encoding.
package picorv32_pkg;

  localparam int RF_AW = 6;
  localparam int RF_DW = 32;

  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DBG_RD  = 2'd2;
  localparam logic [1:0] ST_DBG_ACK = 2'd3;

endpackage

// File: rtl/picorv32_regs_ctrl.sv
// Regfile initiator: clears every entry after reset, then muxes CPU and halted-debug accesses.
//  state      | meaning
//  CLEAR      | sweep writes INIT_VALUE to entries 0..NUM_REGS-1
//  RUN        | CPU pass-through; debug accepted while cpu_halted
//  DBG_RD     | read port 1 steered to the latched debug address
//  DBG_ACK    | one-cycle dbg_ack; new requests not sampled
module picorv32_regs_ctrl
  import picorv32_pkg::*;
#(
  parameter int               NUM_REGS   = 64,
  parameter logic [RF_DW-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_wen,
  input  logic [RF_AW-1:0] cpu_waddr,
  input  logic [RF_DW-1:0] cpu_wdata,
  input  logic [RF_AW-1:0] cpu_raddr1,
  input  logic [RF_AW-1:0] cpu_raddr2,
  output logic [RF_DW-1:0] cpu_rdata1,
  output logic [RF_DW-1:0] cpu_rdata2,
  input  logic             cpu_halted,
  output logic             rf_ready,
  output logic             rf_wen,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [RF_DW-1:0] rf_wdata,
  output logic [RF_AW-1:0] rf_raddr1,
  output logic [RF_AW-1:0] rf_raddr2,
  input  logic [RF_DW-1:0] rf_rdata1,
  input  logic [RF_DW-1:0] rf_rdata2,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [RF_AW-1:0] dbg_addr,
  input  logic [RF_DW-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [RF_DW-1:0] dbg_rdata
);

  localparam logic [RF_AW-1:0] LAST = RF_AW'(NUM_REGS - 1);

  logic [1:0]       state, state_nxt;
  logic [RF_AW-1:0] cnt;
  logic [RF_AW-1:0] dbg_addr_q;
  logic             dbg_go;

  assign dbg_go     = (state == ST_RUN) && dbg_req && cpu_halted;
  assign dbg_ack    = (state == ST_DBG_ACK);
  assign cpu_rdata1 = rf_rdata1;
  assign cpu_rdata2 = rf_rdata2;
  assign rf_raddr2  = cpu_raddr2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      cnt        <= '0;
      rf_ready   <= 1'b0;
      dbg_rdata  <= '0;
      dbg_addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        cnt <= cnt + RF_AW'(1);
        if (cnt == LAST) rf_ready <= 1'b1;
      end
      if (dbg_go && !dbg_we) dbg_addr_q <= dbg_addr;
      if (state == ST_DBG_RD) dbg_rdata <= rf_rdata1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR:   if (cnt == LAST) state_nxt = ST_RUN;
      ST_RUN:     if (dbg_go) state_nxt = dbg_we ? ST_DBG_ACK : ST_DBG_RD;
      ST_DBG_RD:  state_nxt = ST_DBG_ACK;
      ST_DBG_ACK: state_nxt = ST_RUN;
      default:    state_nxt = ST_CLEAR;
    endcase
  end

  // A debug write replaces the CPU write of that cycle; rst_n gates the sweep strobe directly.
  always_comb begin
    rf_wen    = cpu_wen;
    rf_waddr  = cpu_waddr;
    rf_wdata  = cpu_wdata;
    rf_raddr1 = cpu_raddr1;
    case (state)
      ST_CLEAR: begin
        rf_wen   = rst_n;
        rf_waddr = cnt;
        rf_wdata = INIT_VALUE;
      end
      ST_RUN: begin
        if (dbg_go && dbg_we) begin
          rf_wen   = 1'b1;
          rf_waddr = dbg_addr;
          rf_wdata = dbg_wdata;
        end
      end
      ST_DBG_RD: rf_raddr1 = dbg_addr_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picorv32_regs_ctrl.sv
// Scoreboard bench for picorv32_regs_ctrl with a behavioural 1W/2R regfile attached.
module tb_picorv32_regs_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_wen = 1'b0;
  logic [5:0]  cpu_waddr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [5:0]  cpu_raddr1 = '0;
  logic [5:0]  cpu_raddr2 = '0;
  logic [31:0] cpu_rdata1, cpu_rdata2;
  logic        cpu_halted = 1'b0;
  logic        rf_ready, rf_wen;
  logic [5:0]  rf_waddr, rf_raddr1, rf_raddr2;
  logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [5:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;

  always #5 clk = ~clk;

  picorv32_regs_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_raddr1(cpu_raddr1), .cpu_raddr2(cpu_raddr2),
    .cpu_rdata1(cpu_rdata1), .cpu_rdata2(cpu_rdata2),
    .cpu_halted(cpu_halted), .rf_ready(rf_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata)
  );

  // Regfile model, preloaded with junk so the sweep is observable.
  logic [31:0] mem [64] = '{default: 32'hA5A5A5A5};
  always @(posedge clk) if (rf_wen) mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = mem[rf_raddr1];
  assign rf_rdata2 = mem[rf_raddr2];

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit chk_rd; logic [31:0] d; } ack_t;
  wr_t  wq[$];
  ack_t aq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) wq.push_back('{a: 6'(i), d: 32'h0});
  endtask

  // Monitor: every observed regfile write and every dbg_ack must match the next expected entry.
  initial begin
    wr_t  w;
    ack_t k;
    forever begin
      @(negedge clk);
      if (rf_wen) begin
        if (wq.size() == 0) chk("unexpected_write_addr", {26'h0, rf_waddr}, 32'hFFFFFFFF);
        else begin
          w = wq.pop_front();
          chk("write_addr", {26'h0, rf_waddr}, {26'h0, w.a});
          chk("write_data", rf_wdata, w.d);
        end
      end
      if (dbg_ack) begin
        if (aq.size() == 0) chk("unexpected_ack", 32'h1, 32'h0);
        else begin
          k = aq.pop_front();
          if (k.chk_rd) chk("dbg_rdata", dbg_rdata, k.d);
        end
      end
    end
  end

  task automatic dbg_access(input logic we, input logic [5:0] a, input logic [31:0] d,
                            input bit cpu_wr, input int exp_lat);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    cpu_halted = 1'b1;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    if (cpu_wr) begin
      cpu_wen = 1'b1; cpu_waddr = 6'd9; cpu_wdata = 32'hFFFF0000;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) cpu_wen = 1'b0;
      if (!we && i == 1) chk("dbg_rd_raddr1", {26'h0, rf_raddr1}, {26'h0, a});
      if (dbg_ack) begin
        lat = i;
        break;
      end
    end
    chk("dbg_latency", lat, exp_lat);
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  task automatic sweep_after_release(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk);
      if (k == 0 || k == 63) chk({tag, "_ready_low"}, {31'h0, rf_ready}, 32'h0);
      if (k == 64) chk({tag, "_ready_high"}, {31'h0, rf_ready}, 32'h1);
    end
    chk({tag, "_writes_left"}, wq.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then full sweep
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, rf_ready}, 32'h0);
    chk("rst_wen", {31'h0, rf_wen}, 32'h0);
    chk("rst_ack", {31'h0, dbg_ack}, 32'h0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    push_sweep(64);
    sweep_after_release("sweep");
    for (int a = 0; a < 64; a += 21) begin
      cpu_raddr1 = 6'(a);
      @(negedge clk);
      chk("sweep_cleared", cpu_rdata1, 32'h0);
    end

    // 2: CPU write passes straight through
    @(posedge clk); #1;
    wq.push_back('{a: 6'd5, d: 32'hDEADBEEF});
    cpu_wen = 1'b1; cpu_waddr = 6'd5; cpu_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    cpu_wen = 1'b0; cpu_raddr1 = 6'd5;
    @(negedge clk);
    chk("cpu_raddr1", {26'h0, rf_raddr1}, 32'd5);
    chk("cpu_read5", cpu_rdata1, 32'hDEADBEEF);

    // 3: debug write, concurrent CPU write dropped
    wq.push_back('{a: 6'd7, d: 32'h12345678});
    aq.push_back('{chk_rd: 1'b0, d: 32'h0});
    dbg_access(1'b1, 6'd7, 32'h12345678, 1'b1, 1);
    cpu_halted = 1'b0;
    cpu_raddr1 = 6'd7; cpu_raddr2 = 6'd9;
    @(negedge clk);
    chk("cpu_read7", cpu_rdata1, 32'h12345678);
    chk("cpu_write_dropped", cpu_rdata2, 32'h0);

    // 4: debug read of x5
    cpu_raddr1 = 6'd0;
    aq.push_back('{chk_rd: 1'b1, d: 32'hDEADBEEF});
    dbg_access(1'b0, 6'd5, 32'h0, 1'b0, 2);
    repeat (3) @(negedge clk);
    chk("dbg_rdata_held", dbg_rdata, 32'hDEADBEEF);

    // 5: request ignored until the CPU halts
    @(posedge clk); #1;
    cpu_halted = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 6'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_ack_unhalted", {31'h0, dbg_ack}, 32'h0);
    end
    aq.push_back('{chk_rd: 1'b1, d: 32'h12345678});
    dbg_access(1'b0, 6'd7, 32'h0, 1'b0, 2);
    cpu_halted = 1'b0;

    // 6: reset at sweep cycle 20 aborts and restarts the sweep
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_rdata", dbg_rdata, 32'h0);
    push_sweep(20);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_wen", {31'h0, rf_wen}, 32'h0);
    chk("abort_ready", {31'h0, rf_ready}, 32'h0);
    chk("abort_writes_left", wq.size(), 32'h0);
    push_sweep(64);
    sweep_after_release("resweep");
    chk("acks_left", aq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
